// File: rtl/uart_tx.sv
// UART transmitter fed from a TX FIFO; pops one word per frame.
// Start, DBIT data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx #(
  parameter int DBIT         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rd_data,
  output logic            fifo_rd_en,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NW = $clog2(DBIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] S_LAST = NW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [NW-1:0]   r_n, w_n_n;
  logic [DBIT-1:0] r_sh, w_sh_n;
  logic            r_par, w_par_n;
  logic            r_tx, w_tx_n;
  logic            r_rd_en, w_rd_en_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_n     <= w_n_n;
      r_sh    <= w_sh_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_rd_en <= w_rd_en_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_n_n     = r_n;
    w_sh_n    = r_sh;
    w_par_n   = r_par;
    w_tx_n    = r_tx;
    w_rd_en_n = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
        if (!fifo_empty) begin
          w_state_n = S_REQ;
          w_rd_en_n = 1'b1;
        end
      end
      S_REQ: w_state_n = S_LOAD;
      S_LOAD: begin
        // parity is taken here since the shift register is consumed later
        w_sh_n    = fifo_rd_data;
        w_par_n   = (^fifo_rd_data) ^ (PARITY_ODD != 0);
        w_tx_n    = 1'b0;
        w_cnt_n   = '0;
        w_state_n = S_START;
      end
      S_START: begin
        if (r_cnt == C_LAST) begin
          w_cnt_n   = '0;
          w_n_n     = '0;
          w_tx_n    = r_sh[0];
          w_state_n = S_DATA;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == C_LAST) begin
          w_cnt_n = '0;
          w_sh_n  = r_sh >> 1;
          if (r_n == N_LAST) begin
            w_n_n = '0;
            if (PARITY_EN != 0) begin
              w_state_n = S_PARITY;
              w_tx_n    = r_par;
            end else begin
              w_state_n = S_STOP;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_n_n  = r_n + 1'b1;
            w_tx_n = r_sh[1];
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (r_cnt == C_LAST) begin
          w_cnt_n   = '0;
          w_n_n     = '0;
          w_tx_n    = 1'b1;
          w_state_n = S_STOP;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        w_tx_n = 1'b1;
        if (r_cnt == C_LAST) begin
          w_cnt_n = '0;
          if (r_n == S_LAST) begin
            w_n_n     = '0;
            w_state_n = S_IDLE;
          end else begin
            w_n_n = r_n + 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    w_busy_n = (w_state_n != S_IDLE);
    // the tick is registered, so flag the clk that will be the last one
    w_done_n = (w_state_n == S_STOP) && (w_cnt_n == C_LAST) &&
               (w_n_n == S_LAST);
  end

  assign fifo_rd_en   = r_rd_en;
  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameter sets driven in lockstep
// from one FIFO model, checked against a bit-level frame model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic [3:0] rd_en, txs, busy, done;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] q[$];

  // per-instance parameters: default, even parity, odd parity, 2 stops
  int pen[4]  = '{0, 1, 1, 0};
  int podd[4] = '{0, 0, 1, 0};
  int pstp[4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .CLKS_PER_BIT(4)) u0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en[0]),
    .tx(txs[0]), .tx_busy(busy[0]), .tx_done_tick(done[0]));
  uart_tx #(.DBIT(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en[1]),
    .tx(txs[1]), .tx_busy(busy[1]), .tx_done_tick(done[1]));
  uart_tx #(.DBIT(8), .CLKS_PER_BIT(4), .PARITY_EN(1),
            .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en[2]),
    .tx(txs[2]), .tx_busy(busy[2]), .tx_done_tick(done[2]));
  uart_tx #(.DBIT(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en[3]),
    .tx(txs[3]), .tx_busy(busy[3]), .tx_done_tick(done[3]));

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // FIFO model: word appears on the read port the clk after the pop
  task automatic tick();
    @(negedge clk);
    if (rd_en[0] && q.size() > 0) fifo_rd_data = q.pop_front();
    fifo_empty = (q.size() == 0);
  endtask

  // expected line level at frame clk k (1 = first clk of start bit)
  function automatic logic exp_tx(input logic [7:0] d, input int pe,
                                  input int od, input int k);
    int b;
    b = (k - 1) / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe != 0 && b == 9) return (^d) ^ od[0];
    return 1'b1;
  endfunction

  task automatic check_frame(input logic [7:0] d);
    int len;
    q.push_back(d);
    fifo_empty = 1'b0;
    tick();
    chk1($sformatf("req_rd_en_%h", d), rd_en[0], 1'b1);
    chk1($sformatf("req_busy_%h", d), busy[0], 1'b1);
    chk1($sformatf("req_tx_%h", d), txs[0], 1'b1);
    tick();
    chk1($sformatf("load_rd_en_%h", d), rd_en[0], 1'b0);
    chk1($sformatf("load_tx_%h", d), txs[0], 1'b1);
    for (int k = 1; k <= 46; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        len = (1 + 8 + pen[i] + pstp[i]) * 4;
        chk1($sformatf("tx_u%0d_%h_k%0d", i, d, k), txs[i],
             exp_tx(d, pen[i], podd[i], k));
        chk1($sformatf("done_u%0d_%h_k%0d", i, d, k), done[i],
             k == len);
        chk1($sformatf("busy_u%0d_%h_k%0d", i, d, k), busy[i],
             k <= len);
        chk1($sformatf("rd_en_u%0d_%h_k%0d", i, d, k), rd_en[i],
             1'b0);
      end
    end
  endtask

  initial begin
    int rd_cnt;
    int done_cnt;
    logic e;
    repeat (2) @(negedge clk);
    chk1("rst_tx", txs[0], 1'b1);
    chk1("rst_busy", busy[0], 1'b0);
    chk1("rst_rd_en", rd_en[0], 1'b0);
    chk1("rst_done", done[0], 1'b0);
    rst = 1'b0;
    tick();

    check_frame(8'h55);
    check_frame(8'h07);
    check_frame(8'hFF);

    // back-to-back words on the default instance
    q.push_back(8'hA3);
    q.push_back(8'h3C);
    fifo_empty = 1'b0;
    rd_cnt = 0;
    done_cnt = 0;
    tick();
    if (rd_en[0]) rd_cnt++;
    tick();
    for (int k = 1; k <= 86; k++) begin
      tick();
      if (rd_en[0]) rd_cnt++;
      if (done[0]) done_cnt++;
      e = (k <= 43) ? exp_tx(8'hA3, 0, 0, k)
                    : exp_tx(8'h3C, 0, 0, k - 43);
      chk1($sformatf("b2b_tx_k%0d", k), txs[0], e);
    end
    chkn("b2b_rd_en_pulses", rd_cnt, 2);
    chkn("b2b_done_pulses", done_cnt, 2);
    repeat (10) tick();

    // reset during data bit 3 of an all-zero word
    q.push_back(8'h00);
    fifo_empty = 1'b0;
    tick();
    tick();
    for (int k = 1; k <= 18; k++) tick();
    chk1("pre_rst_tx", txs[0], 1'b0);
    chk1("pre_rst_busy", busy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_tx", txs[0], 1'b1);
    chk1("async_rst_busy", busy[0], 1'b0);
    chk1("async_rst_rd_en", rd_en[0], 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk1($sformatf("post_rst_rd_en_%0d", k), rd_en[0], 1'b0);
      chk1($sformatf("post_rst_tx_%0d", k), txs[0], 1'b1);
    end

    // idle with an empty FIFO
    for (int k = 0; k < 100; k++) begin
      tick();
      chk1($sformatf("empty_rd_en_%0d", k), rd_en[0], 1'b0);
      chk1($sformatf("empty_tx_%0d", k), txs[0], 1'b1);
      chk1($sformatf("empty_busy_%0d", k), busy[0], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
